// File: rtl/cm_arb_req_if.sv
// cm_arb_req_if: request / grant / arbiter-side bundle for cm_arb_req.
// slave  : seen by cm_arb_req
// master : seen by the requester/arbiter environment
interface cm_arb_req_if #(
  parameter int DCNT   = 4,
  parameter int DWIDTH = 8
);
  localparam int IDX_WIDTH = (DCNT > 1) ? $clog2(DCNT) : 1;

  logic [DCNT-1:0]             i_req_vld;
  logic [DCNT-1:0]             o_gnt;
  logic [DCNT-1:0]             o_arb_req;
  logic [DCNT-1:0][DWIDTH-1:0] o_arb_weight;
  logic                        i_arb_vld;
  logic [IDX_WIDTH-1:0]        i_arb_gnt;
  logic                        o_busy;
  logic                        o_err;

  modport slave (
    input  i_req_vld, i_arb_vld, i_arb_gnt,
    output o_gnt, o_arb_req, o_arb_weight, o_busy, o_err
  );

  modport master (
    output i_req_vld, i_arb_vld, i_arb_gnt,
    input  o_gnt, o_arb_req, o_arb_weight, o_busy, o_err
  );
endinterface

// File: rtl/cm_arb_req.sv
// cm_arb_req: age-tracking request front end for an external pipelined
// max-weight arbiter. One arbitration in flight at a time:
// IDLE issues the request mask, WAIT collects the arbiter result,
// GNT presents a one-hot grant for a single cycle.
// Optional feature: define CM_ARB_REQ_TIMEOUT_EN to enable the WAIT
// watchdog and the sticky o_err flag.
module cm_arb_req #(
  parameter int DCNT    = 4,
  parameter int DWIDTH  = 8,
  parameter int REG_CNT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  cm_arb_req_if.slave  bus
);
  localparam int IDX_WIDTH = $clog2(DCNT);

  if (DCNT < 2) begin : g_dcnt_chk
    $error("cm_arb_req: DCNT must be >= 2");
  end
  if (REG_CNT < 1) begin : g_reg_cnt_chk
    $error("cm_arb_req: REG_CNT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GNT
  } state_t;

  state_t                      state;
  logic [IDX_WIDTH-1:0]        gnt_idx;
  logic [DCNT-1:0][DWIDTH-1:0] age;
  logic [DCNT-1:0]             gnt_onehot;
  logic [DCNT-1:0]             gnt;

`ifdef CM_ARB_REQ_TIMEOUT_EN
  localparam int unsigned TO_CYC = 2 * REG_CNT + 4;
  localparam int unsigned WCNT_W = $clog2(TO_CYC);
  logic [WCNT_W-1:0] wait_cnt;
  logic              err;
`endif

  // Decode the registered winner; out-of-range indices match no channel
  always_comb begin
    gnt_onehot = '0;
    if (state == GNT) begin
      for (int unsigned i = 0; i < DCNT; i++) begin
        if (32'(gnt_idx) == i) gnt_onehot[i] = 1'b1;
      end
    end
  end

  // Withdrawn requesters receive no grant
  assign gnt = gnt_onehot & bus.i_req_vld;

  assign bus.o_gnt        = gnt;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_arb_weight = age;
  // Issue is combinational on the IDLE cycle; gated by reset so that
  // held requests cannot leak to the arbiter while reset is asserted.
  assign bus.o_arb_req    = (i_rst_n && state == IDLE) ? bus.i_req_vld : '0;

`ifdef CM_ARB_REQ_TIMEOUT_EN
  assign bus.o_err = err;
`else
  assign bus.o_err = 1'b0;
`endif

  // Per-channel age: count waiting cycles, saturate, clear on grant or drop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      age <= '0;
    end else begin
      for (int unsigned i = 0; i < DCNT; i++) begin
        if (!bus.i_req_vld[i] || gnt[i]) begin
          age[i] <= '0;
        end else if (age[i] != '1) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  // Arbitration sequencer: issue, wait for result, grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
`ifdef CM_ARB_REQ_TIMEOUT_EN
      wait_cnt <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.i_req_vld) begin
            state <= WAIT;
`ifdef CM_ARB_REQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.i_arb_vld) begin
            gnt_idx <= bus.i_arb_gnt;
            state   <= GNT;
          end
`ifdef CM_ARB_REQ_TIMEOUT_EN
          else if (wait_cnt == WCNT_W'(TO_CYC - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        GNT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cm_arb_req.md
CM_ARB_REQ -- requirements
Module: cm_arb_req

Interface
REQ-001 SHALL have parameter DCNT, default 4: requester channel count, >= 2.
REQ-002 SHALL have parameter DWIDTH, default 8: age/weight width.
REQ-003 SHALL have parameter REG_CNT, default 2: latency of the attached arbiter in cycles, >= 1; elaboration assertion fails otherwise.
REQ-004 SHALL have localparam IDX_WIDTH = sclog2(DCNT).
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-007 i_req_vld  in  DCNT  per-channel request valid, held until granted.
REQ-008 o_gnt  out  DCNT  one-hot grant; acts as ready; a transfer completes when o_gnt[i] & i_req_vld[i].
REQ-009 o_arb_req  out  DCNT  request mask to arbiter.
REQ-010 o_arb_weight  out  DCNT x DWIDTH  per-channel weight (age) to arbiter.
REQ-011 i_arb_vld  in  1  arbiter result valid.
REQ-012 i_arb_gnt  in  IDX_WIDTH  arbiter winning index.
REQ-013 o_busy  out  1  high while an arbitration is in flight (states WAIT, GNT).
REQ-014 o_err  out  1  sticky timeout flag (present only per REQ-034).

Function
REQ-015 FSM states SHALL be IDLE, WAIT, GNT.
REQ-016 IDLE: if |i_req_vld, drive o_arb_req = i_req_vld for exactly that cycle, load wait counter with 0, go to WAIT; otherwise stay.
REQ-017 o_arb_req SHALL be all-zero in every cycle other than the IDLE issue cycle, so exactly one arbitration is in flight.
REQ-018 o_arb_weight[i] SHALL equal age[i] combinationally in every cycle.
REQ-019 WAIT: on i_arb_vld=1, register i_arb_gnt and go to GNT; i_arb_vld outside WAIT SHALL be ignored.
REQ-020 GNT: o_gnt SHALL be one-hot at the registered index for exactly one cycle, masked by i_req_vld (withdrawn requester gets zero grant, counted as dropped); next state IDLE.
REQ-021 Issue-to-grant latency SHALL be REG_CNT+1 cycles; back-to-back issue period SHALL be REG_CNT+2 cycles.
REQ-022 age[i] SHALL increment by 1 each cycle i_req_vld[i]=1 and o_gnt[i]=0, saturating at 2^DWIDTH-1 (no wrap).
REQ-023 age[i] SHALL clear to 0 in the cycle after o_gnt[i]=1 or any cycle i_req_vld[i]=0.
REQ-024 Registered index >= DCNT SHALL produce no grant and return to IDLE.
REQ-025 Requests arriving during WAIT/GNT SHALL accumulate age and be arbitrated at the next IDLE issue.
REQ-026 Arbiter SHALL be configured ARB_MAX so oldest requester wins; ties resolved by the arbiter.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately force state IDLE, all age[i]=0, wait counter=0, registered index=0.
REQ-028 During reset o_gnt=0, o_arb_req=0, o_arb_weight=0, o_busy=0, o_err=0.
REQ-029 Reset mid-arbitration SHALL discard the in-flight result; a late i_arb_vld after release SHALL be ignored (state IDLE).
REQ-030 Deassertion SHALL be synchronised by the user; first issue no earlier than first rising edge after release.

Configuration
REQ-031 Macro CM_ARB_REQ_TIMEOUT_EN SHALL select the WAIT watchdog.
REQ-032 Defined: wait counter increments each WAIT cycle; at 2*REG_CNT+4 cycles without i_arb_vld, set o_err (sticky until reset), go to IDLE, no grant.
REQ-033 Undefined: WAIT waits indefinitely; no counter logic.
REQ-034 Undefined: o_err SHALL be tied 0.

Verification
REQ-035 DCNT=4, REG_CNT=2, i_req_vld=4'b0100 at t0, model arbiter -> o_arb_req=4'b0100 at t0, o_gnt=4'b0100 at t0+3 only.
REQ-036 All four requesting continuously -> each channel granted once within 4 consecutive grants, grants 4 cycles apart.
REQ-037 Channel 0 held 300 cycles, DWIDTH=8 -> o_arb_weight[0] saturates at 255, never wraps to 0.
REQ-038 i_req_vld[1] dropped during WAIT with gnt index 1 returned -> o_gnt=0 in GNT cycle, age[1]=0.
REQ-039 TIMEOUT_EN, arbiter silent -> o_err=1 after 8 WAIT cycles, state IDLE, next request issued normally.
REQ-040 i_rst_n low for one cycle during WAIT -> outputs zero immediately, late i_arb_vld produces no grant.
